// File: rtl/if_pkg.sv
// Shared fetch-stage types: jump encodings, fetch FSM states, fetch entry.
package if_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_JAL  = 2'b01;
  localparam logic [1:0] JUMP_JALR = 2'b10;

  typedef enum logic {
    BOOT,
    RUN
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous FIFO of fetch entries with a single-cycle flush.
// The head is read straight from storage, so it is always a registered value.
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 wdata,
  input  logic                   pop,
  output entry_t                 rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0) && !flush;
  assign do_push = push && !flush &&
                   ((count != FULL) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  // Cleared on reset so an empty queue presents a zero head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Registered-PC fetch front end with credit-based request issue and FIFO.
// Define IF_FETCH_PERF_EN to add perf_fetched / perf_redirects counters.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_src,
  input  logic [1:0]      jump,
  input  logic [XLEN-1:0] branch_addr,
  input  logic [XLEN-1:0] jump_addr,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc4
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_redirects
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;
  logic [XLEN-1:0] pend_pc [DEPTH];
  logic [AW-1:0]   pend_wr;
  logic [AW-1:0]   pend_rd;
  logic            redirect;
  logic            accept;
  logic            rsp;
  logic            enq;
  logic            deq;
  entry_t          head;
  entry_t          wentry;

  assign redirect  = (jump != JUMP_NONE) || pc_src;
  assign target    = (jump != JUMP_NONE) ? jump_addr
                                         : branch_addr;
  assign rsp       = imem_rsp_valid && (inflight != '0);
  assign enq       = rsp && (drop == '0) && !redirect;
  assign deq       = if_valid && id_ready && !redirect;
  assign accept    = imem_req_valid && imem_req_ready;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // Credits cover both buffered entries and every outstanding request,
  // including wrong-path ones that will be discarded on return.
  always_comb begin
    imem_req_valid = 1'b0;
    if (state == RUN) begin
      imem_req_valid = !redirect &&
        ((CW+1)'(count) + (CW+1)'(inflight) < (CW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      pend_wr  <= '0;
      pend_rd  <= '0;
    end else begin
      inflight <= inflight + CW'(accept) - CW'(rsp);
      if (accept) pend_wr <= pend_wr + 1'b1;
      if (rsp)    pend_rd <= pend_rd + 1'b1;
      if (redirect) begin
        fetch_pc <= target;
        drop     <= inflight - CW'(rsp);
      end else begin
        if (accept) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp && (drop != '0)) drop <= drop - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pend_pc[pend_wr] <= fetch_pc;
  end

  assign wentry = '{pc: pend_pc[pend_rd], inst: imem_rsp_data};

  if_fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (enq),
    .wdata (wentry),
    .pop   (deq),
    .rdata (head),
    .count (count)
  );

  assign if_valid = (count != '0);
  assign if_inst  = head.inst;
  assign if_pc    = head.pc;
  assign if_pc4   = head.pc + XLEN'(4);

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
    end else begin
      perf_fetched   <= perf_fetched + 32'(deq);
      perf_redirects <= perf_redirects + 32'(redirect);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-based memory and fetch model,
// directed scenarios followed by randomized traffic.
module tb_if_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_src;
  logic [1:0]  jump;
  logic [31:0] branch_addr;
  logic [31:0] jump_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_redirects;
`endif

  always #5 clk = ~clk;

  if_fetch_queue #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_src         (pc_src),
    .jump           (jump),
    .branch_addr    (branch_addr),
    .jump_addr      (jump_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .id_ready       (id_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .if_pc4         (if_pc4)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_redirects (perf_redirects)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
    bit          discard;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  // memq doubles as memory latency pipe and outstanding-request list
  req_t        memq[$];
  ent_t        fq[$];
  bit          m_run;
  logic [31:0] m_pc;
  int          m_fetched;
  int          m_redirects;
  int          cyc;
  int          since_rst;
  int          first_valid;
  int          checks;
  int          errors;
  int          lat_min, lat_max;
  int          rdy_pct, idr_pct, redir_pct;
  bit          d_pcs;
  logic [1:0]  d_jmp;
  logic [31:0] d_ba, d_ja;
  bit          junk_rsp;
  logic [31:0] acc_log[$];
  logic [31:0] deq_log[$];

  task automatic run_cycle();
    bit          redir, exp_rv, acc, hit, deq;
    logic [31:0] tgt;
    req_t        r;
    @(negedge clk);
    pc_src      = d_pcs;
    jump        = d_jmp;
    branch_addr = d_pcs ? d_ba : $urandom;
    jump_addr   = (d_jmp != 0) ? d_ja : $urandom;
    if (!d_pcs && d_jmp == 0 && redir_pct > 0 &&
        $urandom_range(99) < redir_pct) begin
      case ($urandom_range(2))
        0: begin pc_src = 1; jump = 0; end
        1: begin pc_src = 0; jump = 2'($urandom_range(1, 3)); end
        default: begin pc_src = 1; jump = 2'($urandom_range(1, 3)); end
      endcase
      branch_addr = $urandom & 32'hFFFF_FFFC;
      jump_addr   = $urandom & 32'hFFFF_FFFC;
    end
    d_pcs = 0;
    d_jmp = 0;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    id_ready       = ($urandom_range(99) < idr_pct);
    hit = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rsp_valid = hit || (junk_rsp && memq.size() == 0);
    imem_rsp_data  = hit ? memq[0].data : $urandom;
    junk_rsp = 0;
    #1;
    redir  = (jump != 0) || pc_src;
    tgt    = (jump != 0) ? jump_addr : branch_addr;
    exp_rv = m_run && !redir && (fq.size() + memq.size() < DEPTH);
    checks++;
    if (imem_req_valid !== exp_rv) begin
      errors++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b",
               cyc, imem_req_valid, exp_rv);
    end
    checks++;
    if (imem_addr !== m_pc) begin
      errors++;
      $display("FAIL imem_addr cyc=%0d got=%h exp=%h",
               cyc, imem_addr, m_pc);
    end
    checks++;
    if (if_valid !== (fq.size() > 0)) begin
      errors++;
      $display("FAIL if_valid cyc=%0d got=%b exp=%b",
               cyc, if_valid, fq.size() > 0);
    end
    if (fq.size() > 0) begin
      checks++;
      if (if_pc !== fq[0].pc || if_inst !== fq[0].inst ||
          if_pc4 !== fq[0].pc + 32'd4) begin
        errors++;
        $display("FAIL head cyc=%0d got=%h/%h/%h exp=%h/%h/%h",
                 cyc, if_pc, if_inst, if_pc4,
                 fq[0].pc, fq[0].inst, fq[0].pc + 32'd4);
      end
    end
`ifdef IF_FETCH_PERF_EN
    checks++;
    if (perf_fetched !== 32'(m_fetched) ||
        perf_redirects !== 32'(m_redirects)) begin
      errors++;
      $display("FAIL perf cyc=%0d got=%0d/%0d exp=%0d/%0d",
               cyc, perf_fetched, perf_redirects,
               m_fetched, m_redirects);
    end
`endif
    if (if_valid === 1'b1 && first_valid < 0) first_valid = since_rst;
    acc = exp_rv && imem_req_ready;
    deq = (fq.size() > 0) && id_ready && !redir;
    if (acc) acc_log.push_back(m_pc);
    if (hit) r = memq.pop_front();
    if (redir) begin
      fq.delete();
      foreach (memq[i]) memq[i].discard = 1;
      m_pc = tgt;
      m_redirects++;
    end else begin
      if (deq) begin
        deq_log.push_back(fq[0].pc);
        void'(fq.pop_front());
        m_fetched++;
      end
      if (hit && !r.discard) fq.push_back('{pc: r.addr, inst: r.data});
      if (acc) begin
        memq.push_back('{addr: m_pc, data: $urandom,
                         due: cyc + int'($urandom_range(lat_min, lat_max)),
                         discard: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    m_run = 1;
    cyc++;
    since_rst++;
  endtask

  // Asserted mid-cycle: the clear must be visible before any clock edge.
  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset          = 0;
    imem_rsp_valid = 1;
    imem_rsp_data  = $urandom;
    imem_req_ready = 1;
    id_ready       = 1;
    pc_src         = 0;
    jump           = 0;
    #1;
    checks++;
    if (if_valid !== 0 || imem_req_valid !== 0) begin
      errors++;
      $display("FAIL rst_valid got=%b/%b exp=0/0",
               if_valid, imem_req_valid);
    end
    checks++;
    if (imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL rst_addr got=%h exp=%h", imem_addr, RESET_PC);
    end
    checks++;
    if (if_inst !== 0 || if_pc !== 0 || if_pc4 !== 32'd4) begin
      errors++;
      $display("FAIL rst_head got=%h/%h/%h exp=0/0/4",
               if_inst, if_pc, if_pc4);
    end
    repeat (2) @(posedge clk);
    #2;
    reset          = 1;
    imem_rsp_valid = 0;
    memq.delete();
    fq.delete();
    acc_log.delete();
    deq_log.delete();
    m_pc        = RESET_PC;
    m_run       = 0;
    m_fetched   = 0;
    m_redirects = 0;
    since_rst   = 0;
    first_valid = -1;
  endtask

  task automatic set_mode(input int lmin, input int lmax,
                          input int rdy, input int idr,
                          input int rdr);
    lat_min = lmin; lat_max = lmax;
    rdy_pct = rdy;  idr_pct = idr; redir_pct = rdr;
  endtask

  task automatic test_reset();
    set_mode(1, 1, 100, 100, 0);
    apply_reset();
    junk_rsp = 1;
    repeat (3) run_cycle();
  endtask

  task automatic test_sequential();
    set_mode(1, 1, 100, 100, 0);
    apply_reset();
    repeat (10) run_cycle();
    checks++;
    if (first_valid !== 3) begin
      errors++;
      $display("FAIL first_valid got=%0d exp=3", first_valid);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (acc_log.size() <= i || acc_log[i] !== RESET_PC + 32'(4 * i)) begin
        errors++;
        $display("FAIL seq_req[%0d] n=%0d exp=%h",
                 i, acc_log.size(), RESET_PC + 32'(4 * i));
      end
      checks++;
      if (deq_log.size() <= i || deq_log[i] !== RESET_PC + 32'(4 * i)) begin
        errors++;
        $display("FAIL seq_pc[%0d] n=%0d exp=%h",
                 i, deq_log.size(), RESET_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    set_mode(1, 1, 100, 0, 0);
    apply_reset();
    repeat (12) run_cycle();
    checks++;
    if (acc_log.size() != DEPTH || imem_req_valid !== 0) begin
      errors++;
      $display("FAIL bp_fill got=%0d/%b exp=%0d/0",
               acc_log.size(), imem_req_valid, DEPTH);
    end
    acc_log.delete();
    idr_pct = 100;
    run_cycle();
    idr_pct = 0;
    repeat (8) run_cycle();
    checks++;
    if (acc_log.size() != 1) begin
      errors++;
      $display("FAIL bp_one got=%0d exp=1", acc_log.size());
    end
  endtask

  task automatic test_redirect_discard();
    set_mode(3, 3, 100, 100, 0);
    apply_reset();
    repeat (4) run_cycle();
    d_jmp = 2'b01;
    d_ja  = 32'h10;
    run_cycle();
    acc_log.delete();
    for (int i = 0; i < 10 && acc_log.size() < 2; i++) run_cycle();
    checks++;
    if (acc_log.size() != 2 || acc_log[0] !== 32'h10 ||
        acc_log[1] !== 32'h14) begin
      errors++;
      $display("FAIL rd_reqs n=%0d exp=2 (10,14)", acc_log.size());
    end
    d_pcs = 1;
    d_ba  = 32'h100;
    run_cycle();
    deq_log.delete();
    run_cycle();
    checks++;
    if (if_valid !== 0) begin
      errors++;
      $display("FAIL rd_empty got=%b exp=0", if_valid);
    end
    repeat (10) run_cycle();
    checks++;
    if (deq_log.size() == 0 || deq_log[0] !== 32'h100) begin
      errors++;
      $display("FAIL rd_pc n=%0d exp=00000100", deq_log.size());
    end
  endtask

  task automatic test_jump_priority();
    set_mode(1, 1, 100, 100, 0);
    repeat (5) run_cycle();
    d_jmp = 2'b01;
    d_ja  = 32'h200;
    d_pcs = 1;
    d_ba  = 32'h300;
    run_cycle();
    acc_log.delete();
    run_cycle();
    checks++;
    if (acc_log.size() == 0 || acc_log[0] !== 32'h200) begin
      errors++;
      $display("FAIL jump_prio addr=%h exp=00000200", imem_addr);
    end
  endtask

  task automatic test_wrap();
    bit saw;
    set_mode(1, 1, 100, 100, 0);
    d_jmp = 2'b10;
    d_ja  = 32'hFFFF_FFFC;
    run_cycle();
    acc_log.delete();
    saw = 0;
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      if (if_valid === 1 && if_pc === 32'hFFFF_FFFC) begin
        saw = 1;
        checks++;
        if (if_pc4 !== 32'h0) begin
          errors++;
          $display("FAIL wrap_pc4 got=%h exp=00000000", if_pc4);
        end
      end
    end
    checks++;
    if (!saw || acc_log.size() < 2 || acc_log[0] !== 32'hFFFF_FFFC ||
        acc_log[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_req saw=%b n=%0d exp=FFFFFFFC,0",
               saw, acc_log.size());
    end
  endtask

  task automatic test_reset_midop();
    bit found;
    set_mode(1, 1, 100, 0, 0);
    apply_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      run_cycle();
      found = (fq.size() == 3) && (memq.size() == 1);
    end
    #5;
    checks++;
    if (!found || if_valid !== 1) begin
      errors++;
      $display("FAIL mid_setup found=%b if_valid=%b exp=1/1",
               found, if_valid);
    end
    apply_reset();
    set_mode(1, 1, 100, 100, 0);
    junk_rsp = 1;
    repeat (6) run_cycle();
    checks++;
    if (acc_log.size() == 0 || acc_log[0] !== RESET_PC) begin
      errors++;
      $display("FAIL mid_restart n=%0d exp=%h", acc_log.size(), RESET_PC);
    end
  endtask

  task automatic test_random();
    set_mode(1, 4, 70, 60, 5);
    apply_reset();
    repeat (1500) run_cycle();
    apply_reset();
    set_mode(1, 3, 85, 40, 3);
    repeat (1500) run_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0;
    d_pcs = 0; d_jmp = 0; d_ba = 0; d_ja = 0; junk_rsp = 0;
    reset = 0; pc_src = 0; jump = 0;
    branch_addr = 0; jump_addr = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    id_ready = 0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_discard();
    test_jump_priority();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
